count_window_ctrl: RTL and testbench
====================================

Name: count_window_ctrl

Overview:
Run controller for a free-running CNT_W-bit counter datapath and its trace-capture path.
- On start it clears the counter, enables counting for a programmed run length, and opens and closes a trace window inside the run: on, then off (gap), then on again.
- It reports completion and whether the controlled counter wrapped during the run.
- It sits between the test/control sequencer and the counter and trace-capture logic.

Parameters:
CNT_W, 4, width of the controlled counter (count_in).
TB_W, 8, width of the run timebase and of the cfg_* fields.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  single-cycle run request; accepted only in IDLE.
abort  input  1  terminates a run immediately.
cfg_off_at  input  TB_W  run cycle at which the trace window closes.
cfg_on_at  input  TB_W  run cycle at which the trace window reopens.
cfg_stop_at  input  TB_W  run length in cycles.
count_in  input  CNT_W  current value of the controlled counter.
cnt_clr  output  1  synchronous clear to the counter.
cnt_en  output  1  count enable to the counter.
trace_en  output  1  trace-capture enable.
busy  output  1  high from CLEAR through the last RUN cycle.
done  output  1  one-cycle pulse on normal completion.
cfg_err  output  1  one-cycle pulse when start is rejected because of bad config.
wrap_seen  output  1  sticky flag: the counter wrapped during the current or last run.
tb  output  TB_W  run cycle index.

Behaviour:
- All outputs are registered; tb and wrap_seen are Moore/registered as well.
- Reset (asynchronous, active-high) puts the block in IDLE, and all outputs and tb go to 0.
  - Reset mid-run drops cnt_en and trace_en at once.
  - No done is issued for the interrupted run.
- States are IDLE, CLEAR, RUN_ON1, RUN_OFF, RUN_ON2, DONE.
- IDLE:
  - On start, cfg_* are latched into internal registers.
  - The config is legal only if 0 < off_at < on_at < stop_at.
  - Legal config: go to CLEAR. Illegal config: pulse cfg_err next cycle and stay in IDLE.
  - cfg_* changes after the latch cycle are ignored until the next accepted start.
- CLEAR lasts one cycle.
  - Outputs: cnt_clr=1, cnt_en=0, trace_en=0, busy=1, tb=0.
  - wrap_seen is cleared.
  - Next state is RUN_ON1.
- RUN states:
  - cnt_en=1 and busy=1.
  - tb is 0 in the first RUN_ON1 cycle and increments by 1 each cycle.
  - trace_en=1 in RUN_ON1 and RUN_ON2; trace_en=0 in RUN_OFF.
  - When tb==off_at-1, go RUN_ON1 -> RUN_OFF.
  - When tb==on_at-1, go RUN_OFF -> RUN_ON2.
  - When tb==stop_at-1, go RUN_ON2 -> DONE.
  - Result: trace_en is high for exactly off_at + (stop_at-on_at) cycles, and cnt_en for exactly stop_at cycles.
  - cfg legality guarantees tb never wraps during a run.
- DONE lasts one cycle.
  - Outputs: done=1, cnt_en=0, trace_en=0, busy=0.
  - tb holds its last value (stop_at-1), and the counter holds its final value.
  - Next state is IDLE.
- wrap_seen is set in any RUN cycle where cnt_en=1 and count_in equals all ones; the counter wraps on that edge.
  - It stays set through DONE and IDLE until the next CLEAR.
- abort:
  - In CLEAR or any RUN state, abort sends the block to IDLE on the next edge.
  - cnt_en, trace_en and busy go to 0; done is not pulsed.
  - tb and wrap_seen hold.
- Input-precedence rules:
  - abort in IDLE or DONE has no effect.
  - start and abort together in IDLE: abort wins and start is ignored.
  - start while not in IDLE, including DONE, is ignored with no error.
- cnt_clr is never asserted together with cnt_en.

Test Plan:
- Reset, then a legal run: assert reset, release, start with off=5, on=15, stop=20 (4-bit counter).
  - Expected: cnt_clr for 1 cycle, then cnt_en for 20 cycles.
  - trace_en is high at tb 0–4 and 15–19, and low at tb 5–14.
  - done pulses once; the counter ends at 4; wrap_seen=1.
- Short run without wrap: off=1, on=2, stop=3.
  - Expected: cnt_en for 3 cycles, trace_en pattern 1,0,1.
  - Final count 3, wrap_seen=0, done pulses once.
- Illegal config:
  - start with off=10, on=10, stop=20 -> cfg_err pulses, busy stays 0, the counter is untouched.
  - off=0 gives the same result.
- Abort mid-gap: run with 5/15/20 and assert abort at tb=8.
  - Expected: the next cycle has cnt_en=0, trace_en=0, busy=0, done=0, tb held at 8.
  - A new start afterwards clears wrap_seen and tb.
- Start collisions:
  - start pulsed at tb=3 during a run -> ignored, run length unchanged.
  - start with abort in IDLE -> stays IDLE.
  - start in the DONE cycle -> ignored.
- Asynchronous reset mid-run: reset pulse asserted between clock edges at tb=12.
  - Expected: all outputs 0 immediately, with no done afterwards.

Source files
------------

// File: rtl/count_window_ctrl.sv
// Run controller for a counter datapath: clears it, enables it for a programmed run length,
// and opens a trace window on / off / on inside the run. All outputs are registered.
module count_window_ctrl #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned TB_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [TB_W-1:0]  cfg_off_at,
  input  logic [TB_W-1:0]  cfg_on_at,
  input  logic [TB_W-1:0]  cfg_stop_at,
  input  logic [CNT_W-1:0] count_in,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             trace_en,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             wrap_seen,
  output logic [TB_W-1:0]  tb
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN_ON1,
    RUN_OFF,
    RUN_ON2,
    DONE
  } state_t;

  localparam logic [TB_W-1:0] TB_ONE = TB_W'(1);

  state_t          state, state_d;
  logic [TB_W-1:0] off_q, on_q, stop_q;
  logic [TB_W-1:0] tb_d;
  logic            latch, cfg_legal, in_run;
  logic            wrap_d, cnt_clr_d, cnt_en_d, trace_en_d, busy_d, done_d, cfg_err_d;

  assign cfg_legal = (cfg_off_at != '0) && (cfg_off_at < cfg_on_at) && (cfg_on_at < cfg_stop_at);
  assign in_run    = (state == RUN_ON1) || (state == RUN_OFF) || (state == RUN_ON2);

  always_comb begin
    state_d    = state;
    tb_d       = tb;
    wrap_d     = wrap_seen;
    latch      = 1'b0;
    cfg_err_d  = 1'b0;
    cnt_clr_d  = 1'b0;
    cnt_en_d   = 1'b0;
    trace_en_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    // The counter wraps on this edge whenever it is enabled at all ones, abort or not.
    if (in_run && (count_in == '1)) wrap_d = 1'b1;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          if (cfg_legal) begin
            latch   = 1'b1;
            state_d = CLEAR;
            tb_d    = '0;
            wrap_d  = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        state_d = abort ? IDLE : RUN_ON1;
        tb_d    = '0;
      end
      RUN_ON1: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          tb_d = tb + TB_ONE;
          if (tb == off_q - TB_ONE) state_d = RUN_OFF;
        end
      end
      RUN_OFF: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          tb_d = tb + TB_ONE;
          if (tb == on_q - TB_ONE) state_d = RUN_ON2;
        end
      end
      RUN_ON2: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tb == stop_q - TB_ONE) begin
          state_d = DONE;
        end else begin
          tb_d = tb + TB_ONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    unique case (state_d)
      CLEAR: begin
        cnt_clr_d = 1'b1;
        busy_d    = 1'b1;
      end
      RUN_ON1, RUN_ON2: begin
        cnt_en_d   = 1'b1;
        trace_en_d = 1'b1;
        busy_d     = 1'b1;
      end
      RUN_OFF: begin
        cnt_en_d = 1'b1;
        busy_d   = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      off_q     <= '0;
      on_q      <= '0;
      stop_q    <= '0;
      tb        <= '0;
      wrap_seen <= 1'b0;
      cnt_clr   <= 1'b0;
      cnt_en    <= 1'b0;
      trace_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_d;
      tb        <= tb_d;
      wrap_seen <= wrap_d;
      cnt_clr   <= cnt_clr_d;
      cnt_en    <= cnt_en_d;
      trace_en  <= trace_en_d;
      busy      <= busy_d;
      done      <= done_d;
      cfg_err   <= cfg_err_d;
      if (latch) begin
        off_q  <= cfg_off_at;
        on_q   <= cfg_on_at;
        stop_q <= cfg_stop_at;
      end
    end
  end

endmodule

// File: tb/tb_count_window_ctrl.sv
// Bench for count_window_ctrl: a per-cycle reference model based on run position,
// a table of whole-run vectors, directed corner sequences and random traffic.
module tb_count_window_ctrl;
  localparam int CNT_W = 4;
  localparam int TB_W  = 8;

  logic             clk = 1'b0;
  logic             reset, start, abort;
  logic [TB_W-1:0]  cfg_off_at, cfg_on_at, cfg_stop_at;
  logic [CNT_W-1:0] count = '0;
  logic             cnt_clr, cnt_en, trace_en, busy, done, cfg_err, wrap_seen;
  logic [TB_W-1:0]  tb;

  count_window_ctrl #(.CNT_W(CNT_W), .TB_W(TB_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_off_at(cfg_off_at), .cfg_on_at(cfg_on_at), .cfg_stop_at(cfg_stop_at),
    .count_in(count), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .trace_en(trace_en),
    .busy(busy), .done(done), .cfg_err(cfg_err), .wrap_seen(wrap_seen), .tb(tb)
  );

  always #5 clk = ~clk;

  // Controlled counter
  always @(posedge clk) begin
    if (cnt_clr) count <= '0;
    else if (cnt_en) count <= count + CNT_W'(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pos -1 idle, 0 clear, 1..stop run cycle, stop+1 done.
  int m_pos = -1, m_off = 0, m_on = 0, m_stop = 0, m_tb = 0;
  bit m_wrap = 0, m_err = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pos = -1; m_tb = 0; m_wrap = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (m_pos < 0) begin
        if (start && !abort) begin
          if (cfg_off_at > 0 && cfg_off_at < cfg_on_at && cfg_on_at < cfg_stop_at) begin
            m_off = int'(cfg_off_at); m_on = int'(cfg_on_at); m_stop = int'(cfg_stop_at);
            m_pos = 0; m_tb = 0; m_wrap = 0;
          end else begin
            m_err = 1;
          end
        end
      end else if (m_pos == 0) begin
        if (abort) m_pos = -1;
        else begin m_pos = 1; m_tb = 0; end
      end else if (m_pos <= m_stop) begin
        if (int'(count) == (1 << CNT_W) - 1) m_wrap = 1;
        if (abort) m_pos = -1;
        else if (m_pos == m_stop) m_pos = m_stop + 1;
        else begin m_tb = m_pos; m_pos++; end
      end else begin
        m_pos = -1;
      end
    end
  end

  bit chk_on = 0;
  int n_trace, n_en, n_busy, n_done, n_err;

  task automatic clear_stats();
    n_trace = 0; n_en = 0; n_busy = 0; n_done = 0; n_err = 0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      n_trace += int'(trace_en); n_en += int'(cnt_en); n_busy += int'(busy);
      n_done += int'(done); n_err += int'(cfg_err);
    end
    if (chk_on && !reset) begin
      automatic bit run = (m_pos >= 1) && (m_pos <= m_stop);
      check("cnt_clr",   32'(cnt_clr),   32'(m_pos == 0));
      check("cnt_en",    32'(cnt_en),    32'(run));
      check("trace_en",  32'(trace_en),  32'(run && (m_tb < m_off || m_tb >= m_on)));
      check("busy",      32'(busy),      32'(m_pos >= 0 && m_pos <= m_stop));
      check("done",      32'(done),      32'(m_pos == m_stop + 1));
      check("cfg_err",   32'(cfg_err),   32'(m_err));
      check("wrap_seen", 32'(wrap_seen), 32'(m_wrap));
      check("tb",        32'(tb),        32'(m_tb));
    end
  end

  typedef struct {
    int off, on, stop;
    int x_trace, x_en, x_busy, x_done, x_err, x_count;
    bit x_wrap;
  } vec_t;

  task automatic start_run(input int off, input int on, input int stop);
    @(negedge clk);
    cfg_off_at = TB_W'(off); cfg_on_at = TB_W'(on); cfg_stop_at = TB_W'(stop);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // later config changes must not disturb the latched run
    cfg_off_at = TB_W'($urandom); cfg_on_at = TB_W'($urandom); cfg_stop_at = TB_W'($urandom);
  endtask

  task automatic wait_tb(input int v);
    int k;
    for (k = 0; k < 300; k++) begin
      if (int'(tb) == v && cnt_en) break;
      @(negedge clk);
    end
    if (k == 300) begin
      n_checks++; n_errors++;
      $display("FAIL wait_tb: got timeout expected tb=%0d", v);
    end
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 300) begin
      n_checks++; n_errors++;
      $display("FAIL wait_done: got timeout expected done pulse");
    end
  endtask

  vec_t vecs[$];

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_off_at = '0; cfg_on_at = '0; cfg_stop_at = '0;

    vecs.push_back('{5, 15, 20,    10, 20, 21, 1, 0, 4, 1});
    vecs.push_back('{1, 2, 3,       2,  3,  4, 1, 0, 3, 0});
    vecs.push_back('{10, 10, 20,    0,  0,  0, 0, 1, 3, 0});
    vecs.push_back('{0, 5, 10,      0,  0,  0, 0, 1, 3, 0});
    vecs.push_back('{1, 2, 15,     14, 15, 16, 1, 0, 15, 0});
    vecs.push_back('{3, 4, 4,       0,  0,  0, 0, 1, 15, 0});
    vecs.push_back('{2, 7, 16,     11, 16, 17, 1, 0, 0, 1});
    vecs.push_back('{4, 3, 9,       0,  0,  0, 0, 1, 0, 1});
    vecs.push_back('{1, 2, 17,     16, 17, 18, 1, 0, 1, 1});
    vecs.push_back('{100, 101, 255, 254, 255, 256, 1, 0, 15, 1});

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_cnt_en", 32'(cnt_en), 0);
    check("rst_wrap", 32'(wrap_seen), 0);
    check("rst_tb", 32'(tb), 0);
    reset = 1'b0;
    chk_on = 1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      clear_stats();
      start_run(vecs[i].off, vecs[i].on, vecs[i].stop);
      repeat (vecs[i].stop + 4) @(negedge clk);
      check("vec_trace_cycles", 32'(n_trace), 32'(vecs[i].x_trace));
      check("vec_en_cycles",    32'(n_en),    32'(vecs[i].x_en));
      check("vec_busy_cycles",  32'(n_busy),  32'(vecs[i].x_busy));
      check("vec_done_pulses",  32'(n_done),  32'(vecs[i].x_done));
      check("vec_err_pulses",   32'(n_err),   32'(vecs[i].x_err));
      check("vec_final_count",  32'(count),   32'(vecs[i].x_count));
      check("vec_wrap_seen",    32'(wrap_seen), 32'(vecs[i].x_wrap));
    end

    // start during a run is ignored; start in the DONE cycle is ignored
    clear_stats();
    start_run(5, 15, 20);
    wait_tb(3);
    cfg_off_at = 8'd1; cfg_on_at = 8'd2; cfg_stop_at = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_busy", 32'(busy), 0);
    check("start_in_done_clr", 32'(cnt_clr), 0);
    check("collision_en_cycles", 32'(n_en), 20);
    repeat (3) @(negedge clk);

    // start with abort in IDLE
    cfg_off_at = 8'd5; cfg_on_at = 8'd15; cfg_stop_at = 8'd20;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 0);
    check("start_abort_clr", 32'(cnt_clr), 0);
    check("start_abort_err", 32'(cfg_err), 0);

    // new start after a wrapped run clears wrap_seen and tb; then abort mid-gap
    start_run(5, 15, 20);
    check("clear_wrap", 32'(wrap_seen), 0);
    check("clear_tb", 32'(tb), 0);
    wait_tb(8);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_cnt_en", 32'(cnt_en), 0);
    check("abort_trace", 32'(trace_en), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_tb_hold", 32'(tb), 8);
    clear_stats();
    repeat (25) @(negedge clk);
    check("abort_no_done", 32'(n_done), 0);

    // asynchronous reset between edges mid-run
    start_run(5, 15, 20);
    wait_tb(12);
    #2 reset = 1'b1;
    #1;
    check("arst_cnt_en", 32'(cnt_en), 0);
    check("arst_trace", 32'(trace_en), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_tb", 32'(tb), 0);
    reset = 1'b0;
    clear_stats();
    repeat (25) @(negedge clk);
    check("arst_no_done", 32'(n_done), 0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 39) == 0);
      cfg_off_at  = TB_W'($urandom_range(0, 5));
      cfg_on_at   = cfg_off_at + TB_W'($urandom_range(0, 5));
      cfg_stop_at = cfg_on_at + TB_W'($urandom_range(0, 20));
    end
    start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
